// File: rtl/board_io_avalon.sv
// board_io_avalon: Avalon-MM slave for seven-segment digits, LEDs, synchronised switches and debounced keys with irq
module board_io_avalon #(
  parameter int NUM_DIGITS      = 8,
  parameter int NUM_LEDR        = 18,
  parameter int NUM_LEDG        = 9,
  parameter int NUM_SW          = 18,
  parameter int NUM_KEY         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DATAWIDTH       = 32
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [3:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATAWIDTH-1:0]    avs_writedata,
  output logic [DATAWIDTH-1:0]    avs_readdata,
  output logic                    irq,
  input  logic [NUM_SW-1:0]       sw,
  input  logic [NUM_KEY-1:0]      key_n,
  output logic [NUM_LEDR-1:0]     ledr,
  output logic [NUM_LEDG-1:0]     ledg,
  output logic [7*NUM_DIGITS-1:0] hex
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [4*NUM_DIGITS-1:0]        data_q, data_d;
  logic [NUM_DIGITS-1:0]          en_q, en_d, raw_sel_q, raw_sel_d;
  logic [NUM_DIGITS-1:0][6:0]     raw_q, raw_d, hex_q, hex_d;
  logic [NUM_LEDR-1:0]            ledr_q, ledr_d;
  logic [NUM_LEDG-1:0]            ledg_q, ledg_d;
  logic [NUM_SW-1:0]              sw_s1_q, sw_s2_q;
  logic [NUM_KEY-1:0]             key_s1_q, key_s2_q, stable_q, stable_d, edge_q, edge_d, mask_q, mask_d, toggle;
  logic [NUM_KEY-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [DATAWIDTH-1:0]           rd_q, rd_d, rd_mux, raw_lo, raw_hi;
  logic                           irq_q, irq_d;
  always_comb begin
    data_d    = (avs_write && avs_address == 4'd0) ? avs_writedata[4*NUM_DIGITS-1:0] : data_q;
    en_d      = (avs_write && avs_address == 4'd1) ? avs_writedata[NUM_DIGITS-1:0] : en_q;
    raw_sel_d = (avs_write && avs_address == 4'd1) ? avs_writedata[8+:NUM_DIGITS] : raw_sel_q;
    ledr_d    = (avs_write && avs_address == 4'd4) ? avs_writedata[NUM_LEDR-1:0] : ledr_q;
    ledg_d    = (avs_write && avs_address == 4'd5) ? avs_writedata[NUM_LEDG-1:0] : ledg_q;
    mask_d    = (avs_write && avs_address == 4'd9) ? avs_writedata[NUM_KEY-1:0] : mask_q;
    raw_lo    = '0;
    raw_hi    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      raw_d[i] = (avs_write && avs_address == ((i < 4) ? 4'd2 : 4'd3)) ? avs_writedata[8*(i%4)+:7] : raw_q[i];
      hex_d[i] = !en_q[i] ? 7'h7F : raw_sel_q[i] ? raw_q[i] : SEG[data_q[4*i+:4]];
      if (i < 4) raw_lo[8*(i%4)+:7] = raw_q[i];
      else raw_hi[8*(i%4)+:7] = raw_q[i];
    end
    for (int k = 0; k < NUM_KEY; k++) begin
      toggle[k] = (key_s2_q[k] != stable_q[k]) && (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1));
      cnt_d[k]  = (key_s2_q[k] == stable_q[k] || toggle[k]) ? '0 : cnt_q[k] + CW'(1);
    end
    stable_d = stable_q ^ toggle;
    edge_d   = (edge_q & ~((avs_write && avs_address == 4'd8) ? avs_writedata[NUM_KEY-1:0] : '0))
             | (toggle & ~stable_q);
    irq_d    = |(edge_q & mask_q);
    case (avs_address)
      4'd0:    rd_mux = 32'(data_q);
      4'd1:    rd_mux = (32'(raw_sel_q) << 8) | 32'(en_q);
      4'd2:    rd_mux = raw_lo;
      4'd3:    rd_mux = raw_hi;
      4'd4:    rd_mux = 32'(ledr_q);
      4'd5:    rd_mux = 32'(ledg_q);
      4'd6:    rd_mux = 32'(sw_s2_q);
      4'd7:    rd_mux = 32'(stable_q);
      4'd8:    rd_mux = 32'(edge_q);
      4'd9:    rd_mux = 32'(mask_q);
      default: rd_mux = '0;
    endcase
    rd_d = avs_read ? rd_mux : rd_q;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q    <= '0;
      en_q      <= '0;
      raw_sel_q <= '0;
      raw_q     <= '0;
      hex_q     <= '1;
      ledr_q    <= '0;
      ledg_q    <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      edge_q    <= '0;
      mask_q    <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      en_q      <= en_d;
      raw_sel_q <= raw_sel_d;
      raw_q     <= raw_d;
      hex_q     <= hex_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      key_s1_q  <= ~key_n;
      key_s2_q  <= key_s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      edge_q    <= edge_d;
      mask_q    <= mask_d;
      rd_q      <= rd_d;
      irq_q     <= irq_d;
    end
  end
  assign avs_readdata = rd_q;
  assign irq          = irq_q;
  assign ledr         = ledr_q;
  assign ledg         = ledg_q;
  assign hex          = hex_q;
endmodule

// File: doc/board_io_avalon.md
Name: board_io_avalon

Overview:
- Parametrised Avalon-MM slave that owns the board's human-interface pins: seven-segment digits, red/green LEDs, slide switches and push-buttons.
- Instantiated beside the SoC interconnect in the FPGA top level, clocked from the 50 MHz system clock.
- Adds per-digit hex/raw/blank display modes, synchronised switch readback, debounced keys with press-edge capture and a maskable interrupt.

Parameters:
- NUM_DIGITS, 8: number of 7-segment digits; legal range 1..8.
- NUM_LEDR, 18: red LED count; legal range 1..32.
- NUM_LEDG, 9: green LED count; legal range 1..32.
- NUM_SW, 18: switch count; legal range 1..32.
- NUM_KEY, 4: push-button count; legal range 1..32.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles before a key change is accepted; must be at least 2.
- DATAWIDTH, 32: Avalon data width; fixed at 32.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  4  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- irq  out  1  level interrupt.
- sw  in  NUM_SW  raw switches, asynchronous.
- key_n  in  NUM_KEY  raw buttons, active-low, asynchronous.
- ledr  out  NUM_LEDR  red LEDs.
- ledg  out  NUM_LEDG  green LEDs.
- hex  out  7*NUM_DIGITS  segments, active-low; digit d occupies bits [7d+6:7d]; bit 0 = segment a … bit 6 = segment g.

Behaviour:
- Reset values:
  - All registers 0; avs_readdata 0; irq 0; ledr/ledg 0.
  - Every hex digit = 7'h7F (blank).
  - Debounced key state = released; key counters 0.
- Register map (word address; R/W unless marked):
  - 0 HEX_DATA: nibble d = bits [4d+3:4d].
  - 1 HEX_CTRL: [7:0] digit enable; [15:8] raw-mode select.
  - 2 RAW_LO: digits 0-3 at bits [6:0], [14:8], [22:16], [30:24].
  - 3 RAW_HI: digits 4-7 in the same layout.
  - 4 LEDR.
  - 5 LEDG.
  - 6 SW (RO).
  - 7 KEY_STATE (RO, 1 = pressed).
  - 8 KEY_EDGE (write-1-to-clear).
  - 9 KEY_MASK.
  - 10-15 unmapped.
- Register access rules:
  - Bits beyond a parameter width read 0 and ignore writes.
  - Writes to RO or unmapped addresses are ignored.
  - Unmapped reads return 0.
  - Full-word writes only; no byteenable.
- Avalon timing:
  - No waitrequest.
  - A write takes effect at the clock edge where avs_write is sampled; outputs update the same edge.
  - Read latency is fixed at 1: avs_readdata is registered and holds its value until the next read.
  - avs_read and avs_write asserted together: the write is performed and the read returns pre-write data.
- Digit output function (registered, updates 1 cycle after the control write):
  - enable=0 → 7'h7F.
  - enable=1, raw=1 → raw field.
  - enable=1, raw=0 → decode of the nibble (active-low, g..a):
    - 0=40, 1=79, 2=24, 3=30
    - 4=19, 5=12, 6=02, 7=78
    - 8=00, 9=10, A=08, b=03
    - C=46, d=21, E=06, F=0E
- Switches: 2-flop synchroniser; SW reflects a pin change 2 cycles later.
- Keys, per key:
  - Inputs pass through a 2-flop synchroniser and are inverted to active-high.
  - Counter behaviour:
    - Sync value ≠ stable state → counter increments.
    - Sync value = stable state → counter clears.
    - Counter reaches DEBOUNCE_CYCLES-1 while still different → stable state toggles and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the stable state.
- Edge capture:
  - A released→pressed stable transition sets the key's KEY_EDGE bit.
  - Release transitions set nothing.
  - Set and write-1-clear in the same cycle → set wins.
  - A key held through reset produces an edge DEBOUNCE_CYCLES+2 cycles after reset deassertion.
- irq = |(KEY_EDGE & KEY_MASK), registered; it asserts the cycle after the edge bit sets and deasserts the cycle after clear or mask.
- Reset mid-operation: asynchronous return to all reset values, including discarding a pending readdata.

Test Plan:
- Reset, then idle: hex all 7'h7F, ledr/ledg 0, irq 0; reads of addresses 0-15 return 0 except SW, which returns the synchronised pins.
- Write HEX_DATA=32'h0123ABCD and HEX_CTRL=32'h0000_00FF → digit0=7'h21 (d), digit7=7'h40 (0); read HEX_DATA returns 32'h0123ABCD with latency 1.
- Write HEX_CTRL=32'h0000_0101, RAW_LO=32'h0000_0055 → digit0=7'h55, digits1-7=7'h7F; clearing enable bit 0 blanks digit0.
- DEBOUNCE_CYCLES=8: key_n[2] low for 5 cycles → no change. Held low for 20 cycles → KEY_STATE=4 and KEY_EDGE=4. With KEY_MASK=4, irq rises the next cycle; writing KEY_EDGE=4 drops irq; release causes no new edge.
- Write KEY_EDGE=4 in the same cycle a new key-2 press is accepted → KEY_EDGE bit 2 stays 1 and irq stays 1.
- Write LEDR=32'hFFFF_FFFF with NUM_LEDR=18 → ledr=18'h3FFFF and readback 32'h0003_FFFF. Assert reset mid-burst → ledr=0 immediately, without waiting for a clock edge.
